// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Pixel coordinates (oCol/oRow) and oActiveNext lead the registered sync, display-enable,
// colour and strobe outputs by one enabled cycle, so an upstream source can look up colour
// combinationally from the coordinates.
// Optional build macro: TEST_PATTERN_EN replaces the colour inputs with 8 vertical colour bars.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CW       = 4,
  parameter int unsigned XW       = 11,
  parameter int unsigned YW       = 10
) (
  input  logic          iClock,
  input  logic          iReset,
  input  logic          iEnable,
  input  logic [CW-1:0] iRed,
  input  logic [CW-1:0] iGreen,
  input  logic [CW-1:0] iBlue,
  output logic [XW-1:0] oCol,
  output logic [YW-1:0] oRow,
  output logic          oActiveNext,
  output logic          oHSync,
  output logic          oVSync,
  output logic          oActive,
  output logic [CW-1:0] oRed,
  output logic [CW-1:0] oGreen,
  output logic [CW-1:0] oBlue,
  output logic          oFrameStart,
  output logic          oLineEnd
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Window boundaries in counter width; sync end is always below the total since BP >= 1.
  localparam logic [XW-1:0] HActiveEnd = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HSyncStart = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HSyncEnd   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XW-1:0] HLast      = XW'(HTotal - 1);
  localparam logic [YW-1:0] VActiveEnd = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VSyncStart = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VSyncEnd   = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [YW-1:0] VLast      = YW'(VTotal - 1);

`ifndef SYNTHESIS
  initial begin
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin
      $error("vga_timing_gen: every H_* timing parameter must be >= 1");
    end
    if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin
      $error("vga_timing_gen: every V_* timing parameter must be >= 1");
    end
  end
`endif

  logic [XW-1:0] col_q, col_d;
  logic [YW-1:0] row_q, row_d;

  logic          active_next;
  logic          hsync_d, vsync_d;
  logic [CW-1:0] red_pix, green_pix, blue_pix;
  logic [CW-1:0] red_d, green_d, blue_d;
  logic          frame_start_d, line_end_d;

  logic          hsync_q, vsync_q, active_q;
  logic [CW-1:0] red_q, green_q, blue_q;
  logic          frame_start_q, line_end_q;

  // Next raster position: col wraps at end of line, row wraps only on the last line's wrap.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (iEnable) begin
      if (col_q == HLast) begin
        col_d = '0;
        row_d = (row_q == VLast) ? '0 : row_q + YW'(1);
      end else begin
        col_d = col_q + XW'(1);
      end
    end
  end

  // Raster position counters.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

`ifdef TEST_PATTERN_EN
  logic [31:0] bar_full;
  logic [2:0]  bar;
  logic        unused_tp;

  assign bar_full  = (32'(col_q) * 32'd8) / H_ACTIVE;
  assign bar       = bar_full[2:0];
  assign unused_tp = ^{bar_full[31:3], iRed, iGreen, iBlue};

  // Colour-bar pattern: index bit2 = red, bit1 = green, bit0 = blue, channels all-ones.
  always_comb begin
    red_pix   = {CW{bar[2]}};
    green_pix = {CW{bar[1]}};
    blue_pix  = {CW{bar[0]}};
  end
`else
  // Colour comes straight from the upstream source for the current coordinates.
  always_comb begin
    red_pix   = iRed;
    green_pix = iGreen;
    blue_pix  = iBlue;
  end
`endif

  // Decode the current pixel into the values the output registers will capture.
  always_comb begin
    active_next   = (col_q < HActiveEnd) && (row_q < VActiveEnd);
    hsync_d       = ((col_q >= HSyncStart) && (col_q < HSyncEnd)) ? H_POL : ~H_POL;
    vsync_d       = ((row_q >= VSyncStart) && (row_q < VSyncEnd)) ? V_POL : ~V_POL;
    red_d         = active_next ? red_pix   : '0;
    green_d       = active_next ? green_pix : '0;
    blue_d        = active_next ? blue_pix  : '0;
    frame_start_d = (col_q == '0) && (row_q == '0);
    line_end_d    = (col_q == HLast);
  end

  // Output registers: one enabled cycle behind the coordinates; reset wins over enable.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      active_q      <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      frame_start_q <= 1'b0;
      line_end_q    <= 1'b0;
    end else if (iEnable) begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_next;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      frame_start_q <= frame_start_d;
      line_end_q    <= line_end_d;
    end
  end

  assign oCol        = col_q;
  assign oRow        = row_q;
  assign oActiveNext = active_next;
  assign oHSync      = hsync_q;
  assign oVSync      = vsync_q;
  assign oActive     = active_q;
  assign oRed        = red_q;
  assign oGreen      = green_q;
  assign oBlue       = blue_q;
  assign oFrameStart = frame_start_q;
  assign oLineEnd    = line_end_q;

endmodule
